// File: rtl/stream_demux32_if.sv
// Valid/ready word stream feeding the demux bank.
interface stream_demux32_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/stream_demux32.sv
// Stream-to-parallel loader: writes accepted words in order into 32 held slots,
// exposing them flattened for combinational indexers.
module stream_demux32 #(
  parameter int W        = 8,
  parameter int LAST_IDX = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  stream_demux32_if.slave    s_in,
  output logic [4:0]         wr_idx,
  output logic               busy,
  output logic               frame_done,
  output logic [32*W-1:0]    out_flat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(LAST_IDX);

  state_t         state_q, state_d;
  logic [4:0]     wr_idx_q, wr_idx_d;
  logic           frame_done_q, frame_done_d;
  logic [W-1:0]   slot_q [32];
  logic [W-1:0]   slot_d [32];
  logic           filling;
  logic           accept;

  assign filling        = (state_q == ST_FILL);
  assign accept         = s_in.in_valid & filling;
  assign s_in.in_ready  = filling;
  assign busy           = filling;
  assign wr_idx         = wr_idx_q;
  assign frame_done     = frame_done_q;

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    frame_done_d = 1'b0;
    slot_d       = slot_q;
    // clear wins over start and over a same-cycle accept
    if (clear) begin
      state_d  = ST_IDLE;
      wr_idx_d = '0;
      for (int k = 0; k < 32; k++) slot_d[k] = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (start) begin
            state_d  = ST_FILL;
            wr_idx_d = '0;
          end
        end
        ST_FILL: begin
          if (accept) begin
            slot_d[wr_idx_q] = s_in.in_data;
            if (wr_idx_q == LAST) begin
              state_d      = ST_HOLD;
              wr_idx_d     = '0;
              frame_done_d = 1'b1;
            end else begin
              wr_idx_d = wr_idx_q + 5'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_idx_q     <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 32; k++) slot_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      frame_done_q <= frame_done_d;
      slot_q       <= slot_d;
    end
  end

  for (genvar k = 0; k < 32; k++) begin : g_flat
    assign out_flat[k*W +: W] = slot_q[k];
  end

endmodule

// File: tb/tb_stream_demux32.sv
// Bench for stream_demux32: a full 32-slot instance checked against a frame model,
// plus a 4-slot instance for the short-frame case.
module tb_stream_demux32;

  logic         clk;
  logic         rst;
  logic         a_start, a_clear, b_start, b_clear;
  logic [4:0]   a_wr_idx, b_wr_idx;
  logic         a_busy, b_busy, a_done, b_done;
  logic [255:0] a_flat, b_flat;

  stream_demux32_if #(.W(8)) a_if ();
  stream_demux32_if #(.W(8)) b_if ();

  stream_demux32 #(.W(8), .LAST_IDX(31)) u_a (
    .clock(clk), .reset(rst), .start(a_start), .clear(a_clear), .s_in(a_if.slave),
    .wr_idx(a_wr_idx), .busy(a_busy), .frame_done(a_done), .out_flat(a_flat)
  );

  stream_demux32 #(.W(8), .LAST_IDX(3)) u_b (
    .clock(clk), .reset(rst), .start(b_start), .clear(b_clear), .s_in(b_if.slave),
    .wr_idx(b_wr_idx), .busy(b_busy), .frame_done(b_done), .out_flat(b_flat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame model for instance A: slot contents, position in the frame, filling flag
  logic [7:0] m_slot [32];
  bit         m_fill;
  int         m_pos;
  bit         m_done;

  task automatic step_model();
    m_done = 0;
    if (rst || a_clear) begin
      for (int k = 0; k < 32; k++) m_slot[k] = 8'h00;
      m_fill = 0;
      m_pos  = 0;
    end else if (!m_fill) begin
      if (a_start) begin
        m_fill = 1;
        m_pos  = 0;
      end
    end else if (a_if.in_valid) begin
      m_slot[m_pos] = a_if.in_data;
      m_pos = m_pos + 1;
      if (m_pos == 32) begin
        m_fill = 0;
        m_pos  = 0;
        m_done = 1;
      end
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = m_slot[k];
    return r;
  endfunction

  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    n_cmp++; if (a_flat !== 256'd0) begin n_bad++; $display("FAIL reset_flat: got %h want 0", a_flat); end
    n_cmp++; if (a_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", a_if.in_ready); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", a_done); end
    n_cmp++; if (a_wr_idx !== 5'd0) begin n_bad++; $display("FAIL reset_wr_idx: got %0d want 0", a_wr_idx); end
    n_cmp++; if (b_flat !== 256'd0) begin n_bad++; $display("FAIL reset_b_flat: got %h want 0", b_flat); end
    rst = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    bit bad = 0;
    a_start = 1;
    tick();
    a_start = 0;
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", a_busy); end
    for (int k = 0; k < 32; k++) begin
      a_if.in_valid = 1;
      a_if.in_data  = 8'(k);
      tick();
      if (a_done === 1'b1) pulses++;
      n_cmp++; if (a_wr_idx !== 5'(m_pos)) begin n_bad++; $display("FAIL b2b_wr_idx: got %0d want %0d", a_wr_idx, m_pos); end
    end
    n_cmp++; if (a_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_after_last: got %b want 1", a_done); end
    n_cmp++; if (a_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_hold: got %b want 0", a_if.in_ready); end
    a_if.in_valid = 0;
    tick();
    n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width: got %b want 0", a_done); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    for (int k = 0; k < 32; k++) if (a_flat[k*8 +: 8] !== 8'(k)) bad = 1;
    n_cmp++; if (bad) begin n_bad++; $display("FAIL b2b_slots: got %h want slot k = k", a_flat); end
  endtask

  task automatic test_toggle_valid();
    int accepts = 0;
    int pulses  = 0;
    bit bad = 0;
    a_start = 1;
    tick();
    a_start = 0;
    for (int c = 0; c < 64; c++) begin
      a_if.in_valid = (c % 2 == 0);
      a_if.in_data  = a_if.in_valid ? 8'(accepts) : 8'($urandom);
      tick();
      if (a_if.in_valid) accepts++;
      if (a_done === 1'b1) pulses++;
      n_cmp++; if (a_wr_idx !== 5'(accepts % 32)) begin n_bad++; $display("FAIL toggle_wr_idx: got %0d want %0d", a_wr_idx, accepts % 32); end
      n_cmp++; if (a_done !== m_done) begin n_bad++; $display("FAIL toggle_done: got %b want %b", a_done, m_done); end
    end
    a_if.in_valid = 0;
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL toggle_pulses: got %0d want 1", pulses); end
    for (int k = 0; k < 32; k++) if (a_flat[k*8 +: 8] !== 8'(k)) bad = 1;
    n_cmp++; if (bad) begin n_bad++; $display("FAIL toggle_slots: got %h want slot k = k", a_flat); end
  endtask

  task automatic test_random_stalls();
    int pulses = 0;
    int cyc = 0;
    a_start = 1;
    tick();
    a_start = 0;
    while (pulses == 0 && cyc < 400) begin
      a_if.in_valid = 1'($urandom_range(0, 1));
      a_if.in_data  = 8'($urandom);
      tick();
      cyc++;
      if (a_done === 1'b1) pulses++;
      n_cmp++; if (a_flat !== model_flat()) begin n_bad++; $display("FAIL rand_flat: got %h want %h", a_flat, model_flat()); end
      n_cmp++; if (a_wr_idx !== 5'(m_pos)) begin n_bad++; $display("FAIL rand_wr_idx: got %0d want %0d", a_wr_idx, m_pos); end
      n_cmp++; if (a_done !== m_done) begin n_bad++; $display("FAIL rand_done: got %b want %b", a_done, m_done); end
    end
    a_if.in_valid = 0;
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL rand_frame_end: got %0d pulses in %0d cycles want 1", pulses, cyc); end
  endtask

  task automatic test_short_frame();
    logic [7:0]   words [4];
    logic [255:0] exp;
    words[0] = 8'hCA; words[1] = 8'hFE; words[2] = 8'h12; words[3] = 8'h34;
    exp = '0;
    for (int i = 0; i < 4; i++) exp[i*8 +: 8] = words[i];
    b_start = 1;
    tick();
    b_start = 0;
    for (int i = 0; i < 4; i++) begin
      b_if.in_valid = 1;
      b_if.in_data  = words[i];
      tick();
      if (i < 3) begin
        n_cmp++; if (b_busy !== 1'b1) begin n_bad++; $display("FAIL short_busy: got %b want 1 at word %0d", b_busy, i); end
        n_cmp++; if (b_wr_idx !== 5'(i + 1)) begin n_bad++; $display("FAIL short_wr_idx: got %0d want %0d", b_wr_idx, i + 1); end
      end
    end
    b_if.in_valid = 0;
    n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL short_hold: got busy %b want 0", b_busy); end
    n_cmp++; if (b_done !== 1'b1) begin n_bad++; $display("FAIL short_done: got %b want 1", b_done); end
    n_cmp++; if (b_wr_idx !== 5'd0) begin n_bad++; $display("FAIL short_wr_idx_end: got %0d want 0", b_wr_idx); end
    n_cmp++; if (b_flat !== exp) begin n_bad++; $display("FAIL short_slots: got %h want %h", b_flat, exp); end
    tick();
    n_cmp++; if (b_done !== 1'b0) begin n_bad++; $display("FAIL short_done_width: got %b want 0", b_done); end
  endtask

  task automatic test_restart();
    logic [255:0] exp;
    a_start = 1;
    tick();
    a_start = 0;
    for (int k = 0; k < 32; k++) begin
      a_if.in_valid = 1;
      a_if.in_data  = 8'hAA;
      tick();
    end
    a_if.in_valid = 0;
    tick();
    a_start = 1;
    tick();
    a_start = 0;
    for (int k = 0; k < 2; k++) begin
      a_if.in_valid = 1;
      a_if.in_data  = 8'h55;
      tick();
    end
    a_if.in_valid = 0;
    exp = {{30{8'hAA}}, 8'h55, 8'h55};
    n_cmp++; if (a_flat !== exp) begin n_bad++; $display("FAIL restart_slots: got %h want %h", a_flat, exp); end
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", a_busy); end
    n_cmp++; if (a_wr_idx !== 5'd2) begin n_bad++; $display("FAIL restart_wr_idx: got %0d want 2", a_wr_idx); end
    a_start = 1;
    tick();
    a_start = 0;
    n_cmp++; if (a_wr_idx !== 5'd2) begin n_bad++; $display("FAIL start_in_fill: got %0d want 2", a_wr_idx); end
    n_cmp++; if (a_flat !== model_flat()) begin n_bad++; $display("FAIL start_in_fill_flat: got %h want %h", a_flat, model_flat()); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 8; k++) begin
      a_if.in_valid = 1;
      a_if.in_data  = 8'($urandom);
      tick();
    end
    n_cmp++; if (a_wr_idx !== 5'd10) begin n_bad++; $display("FAIL clear_setup_wr_idx: got %0d want 10", a_wr_idx); end
    a_clear = 1;
    a_if.in_valid = 1;
    a_if.in_data  = 8'h77;
    tick();
    a_clear = 0;
    a_if.in_valid = 0;
    n_cmp++; if (a_flat !== 256'd0) begin n_bad++; $display("FAIL clear_flat: got %h want 0", a_flat); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL clear_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_wr_idx !== 5'd0) begin n_bad++; $display("FAIL clear_wr_idx: got %0d want 0", a_wr_idx); end
    n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL clear_done: got %b want 0", a_done); end
    a_start = 1;
    a_clear = 1;
    tick();
    a_start = 0;
    a_clear = 0;
    n_cmp++; if (a_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL clear_beats_start: got ready %b want 0", a_if.in_ready); end
  endtask

  task automatic test_reset_midframe();
    a_start = 1;
    tick();
    a_start = 0;
    for (int k = 0; k < 20; k++) begin
      a_if.in_valid = 1;
      a_if.in_data  = 8'($urandom_range(1, 255));
      tick();
    end
    n_cmp++; if (a_wr_idx !== 5'd20) begin n_bad++; $display("FAIL midreset_setup: got %0d want 20", a_wr_idx); end
    rst = 1;
    tick();
    rst = 0;
    a_if.in_valid = 0;
    n_cmp++; if (a_flat !== 256'd0) begin n_bad++; $display("FAIL midreset_flat: got %h want 0", a_flat); end
    n_cmp++; if (a_wr_idx !== 5'd0) begin n_bad++; $display("FAIL midreset_wr_idx: got %0d want 0", a_wr_idx); end
    n_cmp++; if (a_busy !== 1'b0 || a_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b/%b want 0/0", a_busy, a_if.in_ready); end
    n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b want 0", a_done); end
    n_cmp++; if (b_flat !== 256'd0) begin n_bad++; $display("FAIL midreset_b_flat: got %h want 0", b_flat); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    clk = 0;
    rst = 1;
    a_start = 0; a_clear = 0; b_start = 0; b_clear = 0;
    a_if.in_valid = 0; a_if.in_data = '0;
    b_if.in_valid = 0; b_if.in_data = '0;
    m_fill = 0; m_pos = 0; m_done = 0;
    for (int k = 0; k < 32; k++) m_slot[k] = 8'h00;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_random_stalls();
    test_short_frame();
    test_restart();
    test_clear();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
